sd_fifo_c: RTL and testbench
============================

SD_FIFO_C -- requirements
Module: sd_fifo_c

Interface
REQ-001 Parameter width, default 8: data bits per entry.
REQ-002 Parameter depth, default 16: memory entries; any integer >=2, not restricted to powers of 2.
REQ-003 Parameter af_thresh, default depth-2: almost_full assertion level, in memory entries.
REQ-004 Derived: asz = $clog2(depth+1); usage width is asz+1 bits.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 c_srdy  input  1  input-side word valid.
REQ-008 c_drdy  output  1  input-side ready.
REQ-009 c_data  input  width  input-side data.
REQ-010 c_commit  input  1  pulse: publish all uncommitted words, including any word accepted this cycle.
REQ-011 c_abort  input  1  pulse: discard all uncommitted words, including any word accepted this cycle.
REQ-012 p_srdy  output  1  output word valid.
REQ-013 p_drdy  input  1  output-side ready.
REQ-014 p_data  output  width  output data, driven from a register.
REQ-015 usage  output  asz+1  total words held (memory entries in use plus output register).
REQ-016 almost_full  output  1  memory occupancy >= af_thresh.

Function
REQ-017 Input transfer occurs when c_srdy and c_drdy are both 1 at the clock edge; output transfer occurs when p_srdy and p_drdy are both 1 at the clock edge.
REQ-018 The block shall keep three pointers, each in 0..depth-1: wr_tmp (speculative write), wr_com (committed write) and rd.
REQ-019 Pointer increment shall wrap from depth-1 to 0; full and empty are tracked by counters, not by pointer wrap bits.
REQ-020 mem_cnt = committed count plus uncommitted count; c_drdy = (mem_cnt < depth), combinational from registered state only.
REQ-021 On an input transfer: write c_data at wr_tmp; wr_tmp advances; uncommitted count increments.
REQ-022 c_commit: wr_com <= post-transfer wr_tmp; committed count += uncommitted count (including a same-cycle write); uncommitted count <= 0.
REQ-023 c_abort: wr_tmp <= wr_com; uncommitted count <= 0; any same-cycle write is discarded.
REQ-024 c_abort and c_commit asserted together: abort wins.
REQ-025 Commit or abort with no uncommitted data and no write: no state change.
REQ-026 The read side shall see only committed entries; uncommitted data shall never reach p_data.
REQ-027 Output register load (prefetch), at a clock edge: when (!p_srdy or output transfer) and committed count > 0 before the edge, p_data <= mem[rd], rd advances, committed count decrements, p_srdy <= 1.
REQ-028 Output register drain: an output transfer with no load at the same edge sets p_srdy <= 0.
REQ-029 Throughput: one word per cycle sustained in both directions, with no bubbles when continuously fed.
REQ-030 Latency: a word written with c_commit at edge N shall appear with p_srdy=1 after edge N+1.
REQ-031 A prefetch and a write or commit at the same edge shall both take effect; counters shall net correctly (+1/-1 on the same edge leaves the count unchanged).
REQ-032 A full memory with simultaneous output load: c_drdy rises the cycle after the load.
REQ-033 usage = mem_cnt + p_srdy; maximum value depth+1.
REQ-034 almost_full = (mem_cnt >= af_thresh), registered-state derived.

Reset
REQ-035 Reset asserted (low) shall immediately clear all pointers and counters and set p_srdy=0, usage=0, almost_full=0; c_drdy then reads 1.
REQ-036 p_data reset value shall be 0; memory contents are not reset.
REQ-037 Reset mid-packet shall discard committed and uncommitted data alike; no output transfer occurs until a new write is committed after reset release.

Verification (depth=4, width=8)
REQ-038 Write A1,A2,A3 with commit on A3, p_drdy=1 -> p_data A1,A2,A3 on consecutive cycles, first valid two edges after the A3 write; usage peaks at 3.
REQ-039 Write B1,B2 then abort; then write C1 with commit -> only C1 is output; usage returns to 0.
REQ-040 p_drdy=0; write and commit 5 words -> the 5th accepted after prefetch (4 memory + 1 register); c_drdy=0 afterwards; usage=5; almost_full=1 at mem_cnt>=2.
REQ-041 Continuous write with commit each cycle over 10 words, p_drdy=1 -> wrap-around at 3->0 is exercised, in-order data, no bubbles after the first output.
REQ-042 c_commit and c_abort in the same cycle as a write -> all uncommitted data dropped; committed count unchanged.
REQ-043 Assert reset with 2 committed and 1 uncommitted word held -> p_srdy=0 and usage=0 immediately; no stale words output after release.

Source files
------------

// File: rtl/sd_fifo_c.sv
// Single-clock FIFO with speculative writes: words stay invisible to the read side
// until c_commit publishes them; c_abort rewinds the write pointer to the last commit.
module sd_fifo_c #(
    parameter int width     = 8,
    parameter int depth     = 16,
    parameter int af_thresh = depth - 2,
    localparam int asz      = $clog2(depth + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [width-1:0] c_data,
    input  logic             c_commit,
    input  logic             c_abort,
    output logic             p_srdy,
    input  logic             p_drdy,
    output logic [width-1:0] p_data,
    output logic [asz:0]     usage,
    output logic             almost_full
);

    localparam int pw = $clog2(depth);
    localparam logic [pw-1:0]  PTR_MAX = pw'(depth - 1);
    localparam logic [asz-1:0] DEPTH_C = asz'(depth);
    localparam logic [asz-1:0] AF_C    = asz'(af_thresh);

    logic [width-1:0] mem_r [depth];
    logic [width-1:0] p_data_r;
    logic [pw-1:0]    wr_tmp_r, wr_com_r, rd_r;
    logic [pw-1:0]    wr_tmp_nxt_s, wr_com_nxt_s, rd_nxt_s, wr_tmp_inc_s;
    logic [asz-1:0]   com_cnt_r, unc_cnt_r;
    logic [asz-1:0]   com_cnt_nxt_s, unc_cnt_nxt_s, unc_post_s, mem_cnt_s, load_dec_s;
    logic             p_srdy_r, p_srdy_nxt_s;
    logic             wr_en_s, out_xfer_s, load_s;

    function automatic logic [pw-1:0] ptr_inc(input logic [pw-1:0] ptr);
        if (ptr == PTR_MAX) begin
            ptr_inc = {pw{1'b0}};
        end else begin
            ptr_inc = ptr + pw'(1'b1);
        end
    endfunction

    assign mem_cnt_s   = com_cnt_r + unc_cnt_r;
    assign c_drdy      = (mem_cnt_s < DEPTH_C);
    assign wr_en_s     = c_srdy & c_drdy;
    assign out_xfer_s  = p_srdy_r & p_drdy;
    // Prefetch only from committed entries, so speculative data never reaches p_data.
    assign load_s      = (~p_srdy_r | out_xfer_s) & (com_cnt_r != {asz{1'b0}});
    assign load_dec_s  = {{(asz-1){1'b0}}, load_s};
    assign p_srdy      = p_srdy_r;
    assign p_data      = p_data_r;
    assign usage       = {1'b0, mem_cnt_s} + {{asz{1'b0}}, p_srdy_r};
    assign almost_full = (mem_cnt_s >= AF_C);

    // Next-state for pointers, counters and output valid; abort takes priority over commit.
    always_comb begin
        wr_tmp_inc_s  = wr_en_s ? ptr_inc(wr_tmp_r) : wr_tmp_r;
        unc_post_s    = unc_cnt_r + {{(asz-1){1'b0}}, wr_en_s};
        wr_tmp_nxt_s  = wr_tmp_inc_s;
        wr_com_nxt_s  = wr_com_r;
        unc_cnt_nxt_s = unc_post_s;
        com_cnt_nxt_s = com_cnt_r - load_dec_s;
        rd_nxt_s      = load_s ? ptr_inc(rd_r) : rd_r;
        p_srdy_nxt_s  = p_srdy_r;
        if (c_abort) begin
            wr_tmp_nxt_s  = wr_com_r;
            unc_cnt_nxt_s = {asz{1'b0}};
        end else if (c_commit) begin
            wr_com_nxt_s  = wr_tmp_inc_s;
            com_cnt_nxt_s = com_cnt_r + unc_post_s - load_dec_s;
            unc_cnt_nxt_s = {asz{1'b0}};
        end else begin
            wr_tmp_nxt_s  = wr_tmp_inc_s;
        end
        if (load_s) begin
            p_srdy_nxt_s = 1'b1;
        end else if (out_xfer_s) begin
            p_srdy_nxt_s = 1'b0;
        end else begin
            p_srdy_nxt_s = p_srdy_r;
        end
    end

    // Control state registers and the output data register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_tmp_r  <= {pw{1'b0}};
            wr_com_r  <= {pw{1'b0}};
            rd_r      <= {pw{1'b0}};
            com_cnt_r <= {asz{1'b0}};
            unc_cnt_r <= {asz{1'b0}};
            p_srdy_r  <= 1'b0;
            p_data_r  <= {width{1'b0}};
        end else begin
            wr_tmp_r  <= wr_tmp_nxt_s;
            wr_com_r  <= wr_com_nxt_s;
            rd_r      <= rd_nxt_s;
            com_cnt_r <= com_cnt_nxt_s;
            unc_cnt_r <= unc_cnt_nxt_s;
            p_srdy_r  <= p_srdy_nxt_s;
            if (load_s) begin
                p_data_r <= mem_r[rd_r];
            end
        end
    end

    // Storage array; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[wr_tmp_r] <= c_data;
        end
    end

endmodule

// File: tb/tb_sd_fifo_c.sv
// Directed bench for sd_fifo_c at depth 4 / width 8 with hand-computed expectations.
module tb_sd_fifo_c;

    logic       clk = 1'b0;
    logic       reset;
    logic       c_srdy, c_drdy, c_commit, c_abort;
    logic [7:0] c_data;
    logic       p_srdy, p_drdy;
    logic [7:0] p_data;
    logic [3:0] usage;
    logic       almost_full;

    int check_cnt = 0;
    int err_cnt   = 0;

    sd_fifo_c #(.width(8), .depth(4)) dut (
        .clk(clk), .reset(reset),
        .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data),
        .c_commit(c_commit), .c_abort(c_abort),
        .p_srdy(p_srdy), .p_drdy(p_drdy), .p_data(p_data),
        .usage(usage), .almost_full(almost_full)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] want);
        check_cnt++;
        if (got !== want) begin
            err_cnt++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    task automatic check_out(input string tag, input logic exp_srdy, input logic [7:0] exp_data,
                             input logic [3:0] exp_usage);
        check_val({tag, "_srdy"}, 16'(p_srdy), 16'(exp_srdy));
        check_val({tag, "_usage"}, 16'(usage), 16'(exp_usage));
        if (exp_srdy) check_val({tag, "_data"}, 16'(p_data), 16'(exp_data));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic srdy, input logic [7:0] d, input logic com, input logic ab);
        c_srdy   = srdy;
        c_data   = d;
        c_commit = com;
        c_abort  = ab;
    endtask

    initial begin
        reset = 1'b0;
        p_drdy = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #2;
        check_out("rst", 1'b0, 8'h00, 4'd0);
        check_val("rst_pdata", 16'(p_data), 16'h0000);
        check_val("rst_af", 16'(almost_full), 16'h0000);
        check_val("rst_drdy", 16'(c_drdy), 16'h0001);
        #1 reset = 1'b1;

        // Three words, commit on the last, streamed out in order.
        p_drdy = 1'b1;
        drive(1'b1, 8'hA1, 1'b0, 1'b0); tick(); check_out("a_w1", 1'b0, 8'h00, 4'd1);
        drive(1'b1, 8'hA2, 1'b0, 1'b0); tick(); check_out("a_w2", 1'b0, 8'h00, 4'd2);
        drive(1'b1, 8'hA3, 1'b1, 1'b0); tick(); check_out("a_w3", 1'b0, 8'h00, 4'd3);
        drive(1'b0, 8'h00, 1'b0, 1'b0); tick(); check_out("a_o1", 1'b1, 8'hA1, 4'd3);
        tick(); check_out("a_o2", 1'b1, 8'hA2, 4'd2);
        tick(); check_out("a_o3", 1'b1, 8'hA3, 4'd1);
        tick(); check_out("a_end", 1'b0, 8'h00, 4'd0);

        // Aborted packet must never appear; only C1 comes out.
        drive(1'b1, 8'hB1, 1'b0, 1'b0); tick(); check_out("b_w1", 1'b0, 8'h00, 4'd1);
        drive(1'b1, 8'hB2, 1'b0, 1'b0); tick(); check_out("b_w2", 1'b0, 8'h00, 4'd2);
        drive(1'b0, 8'h00, 1'b0, 1'b1); tick(); check_out("b_abort", 1'b0, 8'h00, 4'd0);
        drive(1'b1, 8'hC1, 1'b1, 1'b0); tick(); check_out("c_w1", 1'b0, 8'h00, 4'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0); tick(); check_out("c_o1", 1'b1, 8'hC1, 4'd1);
        tick(); check_out("c_end", 1'b0, 8'h00, 4'd0);
        tick(); check_out("c_idle", 1'b0, 8'h00, 4'd0);

        // Fill with the output stalled: 4 in memory plus 1 in the register.
        p_drdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check_val("d_drdy_pre", 16'(c_drdy), 16'h0001);
            drive(1'b1, 8'(8'hD0 + k), 1'b1, 1'b0);
            tick();
            check_out("d_fill", (k != 0), 8'hD0, 4'(k + 1));
            check_val("d_af", 16'(almost_full), 16'(k >= 2));
        end
        check_val("d_full_drdy", 16'(c_drdy), 16'h0000);
        drive(1'b1, 8'hEE, 1'b1, 1'b0); tick(); check_out("d_reject", 1'b1, 8'hD0, 4'd5);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        p_drdy = 1'b1;
        check_val("d_drdy_hold", 16'(c_drdy), 16'h0000);
        tick(); check_out("d_o1", 1'b1, 8'hD1, 4'd4);
        check_val("d_drdy_rise", 16'(c_drdy), 16'h0001);
        tick(); check_out("d_o2", 1'b1, 8'hD2, 4'd3);
        tick(); check_out("d_o3", 1'b1, 8'hD3, 4'd2);
        tick(); check_out("d_o4", 1'b1, 8'hD4, 4'd1);
        tick(); check_out("d_end", 1'b0, 8'h00, 4'd0);

        // Continuous commit-per-word stream; pointers wrap, no bubbles.
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 8'(8'h60 + k), 1'b1, 1'b0);
            tick();
            if (k == 0) check_out("e_first", 1'b0, 8'h00, 4'd1);
            else        check_out("e_stream", 1'b1, 8'(8'h60 + k - 1), 4'd2);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0); tick(); check_out("e_last", 1'b1, 8'h69, 4'd1);
        tick(); check_out("e_end", 1'b0, 8'h00, 4'd0);

        // Commit and abort together with a write: speculative words dropped.
        p_drdy = 1'b0;
        drive(1'b1, 8'hF0, 1'b1, 1'b0); tick(); check_out("f_w0", 1'b0, 8'h00, 4'd1);
        drive(1'b1, 8'hF1, 1'b1, 1'b0); tick(); check_out("f_w1", 1'b1, 8'hF0, 4'd2);
        drive(1'b1, 8'hF2, 1'b0, 1'b0); tick(); check_out("f_w2", 1'b1, 8'hF0, 4'd3);
        drive(1'b1, 8'hF3, 1'b1, 1'b1); tick(); check_out("f_both", 1'b1, 8'hF0, 4'd2);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        p_drdy = 1'b1;
        tick(); check_out("f_o1", 1'b1, 8'hF1, 4'd1);
        tick(); check_out("f_end", 1'b0, 8'h00, 4'd0);
        tick(); check_out("f_idle", 1'b0, 8'h00, 4'd0);

        // Reset while holding committed and uncommitted data.
        p_drdy = 1'b0;
        drive(1'b1, 8'h70, 1'b0, 1'b0); tick(); check_out("g_w0", 1'b0, 8'h00, 4'd1);
        drive(1'b1, 8'h71, 1'b1, 1'b0); tick(); check_out("g_w1", 1'b0, 8'h00, 4'd2);
        drive(1'b1, 8'h72, 1'b0, 1'b0); tick(); check_out("g_w2", 1'b1, 8'h70, 4'd3);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        #2 reset = 1'b0;
        #1;
        check_out("g_rst", 1'b0, 8'h00, 4'd0);
        check_val("g_rst_pdata", 16'(p_data), 16'h0000);
        check_val("g_rst_af", 16'(almost_full), 16'h0000);
        check_val("g_rst_drdy", 16'(c_drdy), 16'h0001);
        #1 reset = 1'b1;
        p_drdy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); check_out("g_stale", 1'b0, 8'h00, 4'd0);
        end
        drive(1'b1, 8'h80, 1'b1, 1'b0); tick(); check_out("h_w0", 1'b0, 8'h00, 4'd1);
        drive(1'b0, 8'h00, 1'b0, 1'b0); tick(); check_out("h_o0", 1'b1, 8'h80, 4'd1);
        tick(); check_out("h_end", 1'b0, 8'h00, 4'd0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
